alu_sequencer: RTL and testbench

//  Multi-cycle control unit for the 8-bit ALU. Accepts one instruction per valid/ready handshake,

---
 rtl/alu_sequencer_if.sv | 50 +++++
 rtl/alu_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Bundles the fetch-side instruction handshake, the OUT port, the ALU control/result bus and status.
// Purely combinational wiring; no latency of its own.
// Handshake is valid/ready on the instruction side; the ALU side has no flow control.
interface alu_sequencer_if #(
    parameter int DW  = 8,
    parameter int RAW = 2
);
    localparam int IW = 4 + 2 * RAW;

    // instruction handshake from fetch
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic [DW-1:0] in_data;

    // OUT instruction result
    logic          out_valid;
    logic [DW-1:0] out_data;

    // ALU controls and operands
    logic          alu_M;
    logic [3:0]    alu_se;
    logic [DW-1:0] alu_S;
    logic [DW-1:0] alu_D;

    // ALU results
    logic [DW-1:0] alu_T;
    logic          alu_Cf;
    logic          alu_Zf;

    // architectural status
    logic          cf;
    logic          zf;
    logic          busy;
    logic          illegal;

    // sequencer view
    modport slave (
        input  instr_valid, instr, in_data, alu_T, alu_Cf, alu_Zf,
        output instr_ready, out_valid, out_data, alu_M, alu_se, alu_S, alu_D,
               cf, zf, busy, illegal
    );

    // fetch / ALU / observer view
    modport master (
        output instr_valid, instr, in_data, alu_T, alu_Cf, alu_Zf,
        input  instr_ready, out_valid, out_data, alu_M, alu_se, alu_S, alu_D,
               cf, zf, busy, illegal
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for the 8-bit ALU: accept, EXEC (drive ALU), WB (write Rd / flags).
// Latency 3 cycles per instruction (accept edge -> EXEC -> WB -> IDLE), no overlap.
// instr_ready only in IDLE and out of reset; a held instr_valid simply waits for the next IDLE.
module alu_sequencer #(
    parameter int DW  = 8,
    parameter int RAW = 2
) (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus
);
    localparam int IW   = 4 + 2 * RAW;
    localparam int NREG = 2 ** RAW;

    localparam logic [3:0] OP_MOV   = 4'b0000;
    localparam logic [3:0] OP_IN    = 4'b0001;
    localparam logic [3:0] OP_PSD_A = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_ADD   = 4'b1001;
    localparam logic [3:0] OP_PSD_B = 4'b1010;
    localparam logic [3:0] OP_AND   = 4'b1011;
    localparam logic [3:0] OP_MOVS  = 4'b1100;
    localparam logic [3:0] OP_OUT   = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // latched instruction
    logic [3:0]     op_q;
    logic [RAW-1:0] rs_q;
    logic [RAW-1:0] rd_q;
    logic [DW-1:0]  in_q;

    // EXEC -> WB staging
    logic [DW-1:0]  res_q;
    logic           cf_stg;
    logic           zf_stg;

    // architectural state
    logic [DW-1:0]  regs [NREG];
    logic           cf_q;
    logic           zf_q;
    logic [DW-1:0]  out_data_q;

    // register file read ports, addressed by the latched instruction
    logic [DW-1:0]  rs_val;
    logic [DW-1:0]  rd_val;

    // decoded controls for the latched opcode
    logic           use_alu;
    logic           dec_M;
    logic [3:0]     dec_se;
    logic           wr_alu;
    logic           wr_in;
    logic           upd_flags;
    logic           is_out;
    logic           is_illegal;

    logic           accept;

    assign accept = bus.instr_valid && bus.instr_ready;
    assign rs_val = regs[rs_q];
    assign rd_val = regs[rd_q];

    // Decode the latched opcode into ALU controls and write-back actions.
    always_comb begin
        use_alu    = 1'b0;
        dec_M      = 1'b0;
        dec_se     = 4'b0000;
        wr_alu     = 1'b0;
        wr_in      = 1'b0;
        upd_flags  = 1'b0;
        is_out     = 1'b0;
        is_illegal = 1'b0;
        case (op_q)
            OP_MOV: begin
                use_alu = 1'b1;
                wr_alu  = 1'b1;
            end
            OP_MOVS, OP_NOT, OP_PSD_A, OP_PSD_B: begin
                use_alu = 1'b1;
                dec_M   = 1'b1;
                dec_se  = op_q;
                wr_alu  = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
                use_alu   = 1'b1;
                dec_M     = 1'b1;
                dec_se    = op_q;
                wr_alu    = 1'b1;
                upd_flags = 1'b1;
            end
            OP_IN: begin
                wr_in = 1'b1;
            end
            OP_OUT: begin
                is_out = 1'b1;
            end
            default: begin
                is_illegal = 1'b1;
            end
        endcase
    end

    // State register; reset aborts any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fixed three-step walk once an instruction is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: ALU bus is only non-zero in EXEC, pulses only in WB and never during reset.
    always_comb begin
        bus.instr_ready = (state_q == S_IDLE) && !rst;
        bus.busy        = (state_q != S_IDLE);
        bus.alu_M       = 1'b0;
        bus.alu_se      = 4'b0000;
        bus.alu_S       = '0;
        bus.alu_D       = '0;
        bus.out_valid   = 1'b0;
        bus.illegal     = 1'b0;
        if (state_q == S_EXEC && use_alu) begin
            bus.alu_M  = dec_M;
            bus.alu_se = dec_se;
            bus.alu_S  = rs_val;
            bus.alu_D  = rd_val;
        end
        if (state_q == S_WB && !rst) begin
            bus.out_valid = is_out;
            bus.illegal   = is_illegal;
        end
    end

    assign bus.cf       = cf_q;
    assign bus.zf       = zf_q;
    assign bus.out_data = out_data_q;

    // Latch the instruction fields and the IN operand on the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= 4'b0000;
            rs_q <= '0;
            rd_q <= '0;
            in_q <= '0;
        end else if (accept) begin
            op_q <= bus.instr[IW-1 -: 4];
            rs_q <= bus.instr[RAW +: RAW];
            rd_q <= bus.instr[RAW-1:0];
            in_q <= bus.in_data;
        end
    end

    // Closing edge of EXEC: stage ALU result/flags; OUT loads out_data so it is valid during WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q      <= '0;
            cf_stg     <= 1'b0;
            zf_stg     <= 1'b0;
            out_data_q <= '0;
        end else if (state_q == S_EXEC) begin
            res_q  <= bus.alu_T;
            cf_stg <= bus.alu_Cf;
            zf_stg <= bus.alu_Zf;
            if (is_out) begin
                out_data_q <= rs_val;
            end
        end
    end

    // Closing edge of WB: commit Rd and, for ADD/SUB/AND, the flags taken verbatim from the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            cf_q <= 1'b0;
            zf_q <= 1'b0;
        end else if (state_q == S_WB) begin
            if (wr_alu) begin
                regs[rd_q] <= res_q;
            end else if (wr_in) begin
                regs[rd_q] <= in_q;
            end
            if (upd_flags) begin
                cf_q <= cf_stg;
                zf_q <= zf_stg;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU closing the loop.
// Each instruction is driven at a falling edge; EXEC/WB/IDLE are sampled on following falling edges.
// Valid is dropped right after the accept edge except in the back-to-back hold test.
module tb_alu_sequencer;
    localparam logic [3:0] OP_MOV  = 4'b0000;
    localparam logic [3:0] OP_IN   = 4'b0001;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_ADD  = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b1011;
    localparam logic [3:0] OP_OUT  = 4'b1111;
    localparam logic [3:0] OP_BAD  = 4'b0011;

    logic clk;
    logic rst;

    int n_chk = 0;
    int n_bad = 0;

    // values captured by run_instr
    logic       ex_M;
    logic [3:0] ex_se;
    logic [7:0] ex_S, ex_D;
    logic       wb_ov, wb_ill, wb_busy, wb_ready;
    logic [7:0] wb_od;
    logic       id_ov, id_ill, id_busy, id_ready;
    logic [7:0] id_od;

    alu_sequencer_if #(.DW(8), .RAW(2)) ifc ();

    alu_sequencer #(.DW(8), .RAW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: carry/borrow from the wide result, zero only when result and carry are both 0.
    always_comb begin
        logic [8:0] wide;
        wide       = {1'b0, ifc.alu_S};
        ifc.alu_T  = ifc.alu_S;
        ifc.alu_Cf = 1'b0;
        ifc.alu_Zf = 1'b0;
        if (ifc.alu_M) begin
            case (ifc.alu_se)
                4'b1001: begin
                    wide       = {1'b0, ifc.alu_S} + {1'b0, ifc.alu_D};
                    ifc.alu_T  = wide[7:0];
                    ifc.alu_Cf = wide[8];
                    ifc.alu_Zf = (wide[7:0] == 8'h00) && !wide[8];
                end
                4'b0110: begin
                    wide       = {1'b0, ifc.alu_D} - {1'b0, ifc.alu_S};
                    ifc.alu_T  = wide[7:0];
                    ifc.alu_Cf = wide[8];
                    ifc.alu_Zf = (wide[7:0] == 8'h00) && !wide[8];
                end
                4'b1011: ifc.alu_T = ifc.alu_S & ifc.alu_D;
                4'b0101: ifc.alu_T = ~ifc.alu_D;
                4'b1010, 4'b0100: ifc.alu_T = ifc.alu_D;
                default: ifc.alu_T = ifc.alu_S;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Issue one instruction from a falling edge and capture EXEC, WB and the following IDLE cycle.
    task automatic run_instr(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rd,
                             input logic [7:0] din);
        int n;
        n = 0;
        while (!ifc.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.instr_ready) chk("ready_timeout", 32'd0, 32'd1);
        ifc.instr_valid = 1'b1;
        ifc.instr       = {op, rs, rd};
        ifc.in_data     = din;
        @(posedge clk);
        #1;
        ifc.instr_valid = 1'b0;
        ifc.in_data     = ~din;
        @(negedge clk);
        ex_M  = ifc.alu_M;
        ex_se = ifc.alu_se;
        ex_S  = ifc.alu_S;
        ex_D  = ifc.alu_D;
        @(negedge clk);
        wb_ov    = ifc.out_valid;
        wb_od    = ifc.out_data;
        wb_ill   = ifc.illegal;
        wb_busy  = ifc.busy;
        wb_ready = ifc.instr_ready;
        @(negedge clk);
        id_ov    = ifc.out_valid;
        id_od    = ifc.out_data;
        id_ill   = ifc.illegal;
        id_busy  = ifc.busy;
        id_ready = ifc.instr_ready;
    endtask

    task automatic read_reg(input logic [1:0] r, output logic [7:0] val);
        run_instr(OP_OUT, r, 2'd0, 8'h00);
        val = wb_od;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got expired want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        int cyc, nacc, did_rst;
        int acc_cyc [4];

        rst             = 1'b1;
        ifc.instr_valid = 1'b0;
        ifc.instr       = '0;
        ifc.in_data     = '0;

        // 1: reset
        @(negedge clk);
        chk("rst_ready", ifc.instr_ready, 1'b0);
        chk("rst_busy", ifc.busy, 1'b0);
        @(negedge clk);
        chk("rst_cf", ifc.cf, 1'b0);
        chk("rst_zf", ifc.zf, 1'b0);
        chk("rst_out_data", ifc.out_data, 8'h00);
        chk("rst_pulses", {ifc.out_valid, ifc.illegal}, 2'b00);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", ifc.instr_ready, 1'b1);
        for (int r = 0; r < 4; r++) begin
            read_reg(r[1:0], v);
            chk($sformatf("rst_R%0d", r), v, 8'h00);
        end
        chk("out_pulse_wb", wb_ov, 1'b1);
        chk("out_pulse_gone", id_ov, 1'b0);

        // 2: ADD with carry out to zero result
        run_instr(OP_IN, 2'd0, 2'd1, 8'h7F);
        run_instr(OP_IN, 2'd0, 2'd2, 8'h81);
        run_instr(OP_ADD, 2'd1, 2'd2, 8'h00);
        chk("add_M_se", {ex_M, ex_se}, 5'b1_1001);
        chk("add_S", ex_S, 8'h7F);
        chk("add_D", ex_D, 8'h81);
        chk("add_cf_zf", {ifc.cf, ifc.zf}, 2'b10);
        read_reg(2'd2, v);
        chk("add_R2", v, 8'h00);

        // 3: SUB to exact zero, then SUB with borrow
        run_instr(OP_IN, 2'd0, 2'd0, 8'h05);
        run_instr(OP_IN, 2'd0, 2'd1, 8'h05);
        run_instr(OP_SUB, 2'd0, 2'd1, 8'h00);
        chk("sub0_se", ex_se, 4'b0110);
        chk("sub0_cf_zf", {ifc.cf, ifc.zf}, 2'b01);
        read_reg(2'd1, v);
        chk("sub0_R1", v, 8'h00);
        run_instr(OP_IN, 2'd0, 2'd2, 8'h03);
        run_instr(OP_SUB, 2'd0, 2'd2, 8'h00);
        chk("subb_cf_zf", {ifc.cf, ifc.zf}, 2'b10);
        read_reg(2'd2, v);
        chk("subb_R2", v, 8'hFE);

        // 4: NOT then OUT; flags kept
        run_instr(OP_IN, 2'd0, 2'd3, 8'h0F);
        run_instr(OP_NOT, 2'd3, 2'd3, 8'h00);
        chk("not_M_se", {ex_M, ex_se}, 5'b1_0101);
        run_instr(OP_OUT, 2'd3, 2'd0, 8'h00);
        chk("out_exec_idle", {ex_M, ex_se, ex_S, ex_D}, 21'd0);
        chk("out_valid_wb", wb_ov, 1'b1);
        chk("out_data_wb", wb_od, 8'hF0);
        chk("out_valid_after", id_ov, 1'b0);
        chk("out_data_hold", id_od, 8'hF0);
        chk("not_flags_kept", {ifc.cf, ifc.zf}, 2'b10);

        // 5: undefined opcode
        run_instr(OP_BAD, 2'd1, 2'd2, 8'h00);
        chk("ill_wb", wb_ill, 1'b1);
        chk("ill_wb_busy_ready", {wb_busy, wb_ready}, 2'b10);
        chk("ill_after", id_ill, 1'b0);
        chk("ill_idle_ready", {id_busy, id_ready}, 2'b01);
        chk("ill_flags_kept", {ifc.cf, ifc.zf}, 2'b10);
        read_reg(2'd2, v);
        chk("ill_R2_kept", v, 8'hFE);

        // AND clears flags; MOV copies with M=0
        run_instr(OP_AND, 2'd3, 2'd2, 8'h00);
        chk("and_cf_zf", {ifc.cf, ifc.zf}, 2'b00);
        run_instr(OP_MOV, 2'd2, 2'd0, 8'h00);
        chk("mov_M_S", {ex_M, ex_S}, 9'h0F0);
        read_reg(2'd0, v);
        chk("mov_R0", v, 8'hF0);

        // 6: valid held across 4 ADDs, reset during EXEC of the 3rd
        run_instr(OP_IN, 2'd0, 2'd1, 8'h01);
        cyc     = 0;
        nacc    = 0;
        did_rst = 0;
        ifc.instr_valid = 1'b1;
        ifc.instr       = {OP_ADD, 2'd1, 2'd2};
        while (nacc < 4 && cyc < 40) begin
            #1;
            if (did_rst == 1) begin
                rst     = 1'b0;
                did_rst = 2;
            end else if (nacc == 3 && did_rst == 0) begin
                rst     = 1'b1;
                did_rst = 1;
                #1;
                chk("abort_no_pulse", {ifc.out_valid, ifc.illegal}, 2'b00);
            end
            #1;
            if (ifc.instr_ready) begin
                acc_cyc[nacc] = cyc;
                nacc++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("hold_accepts", nacc, 4);
        if (nacc == 4) begin
            chk("hold_gap1", acc_cyc[1] - acc_cyc[0], 3);
            chk("hold_gap2", acc_cyc[2] - acc_cyc[1], 3);
            chk("hold_gap_rst", acc_cyc[3] - acc_cyc[2], 2);
        end
        ifc.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_abort_flags", {ifc.cf, ifc.zf}, 2'b01);
        read_reg(2'd2, v);
        chk("post_abort_R2", v, 8'h00);
        read_reg(2'd1, v);
        chk("post_abort_R1", v, 8'h00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
